// File: rtl/sram_share_ctl.sv
// sram_share_ctl
// Arbitrates the expansion SRAM window (B800h-FFFFh, decoded on A15..A11)
// between the Z80 bus and a bulk loader port. The Z80 has fixed priority and
// drives the SRAM strobes combinationally from its live bus. A loader access
// runs a timed setup/strobe/hold sequence; a Z80 window access that arrives
// during a loader cycle is stalled with WAIT_N until the SRAM is free.
//
// Build option: define SRAM_SHARE_LED_STRETCH_EN to stretch the activity LEDs
// with LED_STRETCH_W-bit down counters. Without it the LEDs mirror the chip
// select and write strobe directly and no counters exist.
//
// Loader handshake: LD_REQ is a level request. The controller accepts it in
// IDLE, latches LD_WE, runs the strobe sequence and pulses LD_ACK for one clock
// in the last hold clock (read data is valid on the SRAM bus in that clock).
// LD_REQ may drop early; an accepted access always completes and acknowledges.
// A loader keeping LD_REQ high after LD_ACK gets its next access after exactly
// one IDLE clock, which is the Z80's arbitration slot.

module sram_share_ctl #(
   parameter logic [4:0] WIN_LO        = 5'h17,
   parameter logic [4:0] WIN_HI        = 5'h1F,
   parameter int         LD_SETUP_CYC  = 1,
   parameter int         LD_STROBE_CYC = 2,
   parameter int         LD_HOLD_CYC   = 1
`ifdef SRAM_SHARE_LED_STRETCH_EN
   ,
   parameter int         LED_STRETCH_W = 16
`endif
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [4:0] Addr,
   input  logic       MREQ_N,
   input  logic       RD_N,
   input  logic       WR_N,
   output logic       WAIT_N,
   input  logic       LD_REQ,
   input  logic       LD_WE,
   output logic       LD_ACK,
   output logic       BUS_SEL,
   output logic       RAM_CS_N,
   output logic       RAM_OE_N,
   output logic       RAM_WE_N,
   output logic       led1,
   output logic       led2,
   output logic [2:0] dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_Z80       = 3'd1,
      S_LD_SETUP  = 3'd2,
      S_LD_STROBE = 3'd3,
      S_LD_HOLD   = 3'd4
   } state_t;

   // Phase counter reload values: each loader phase lasts (load + 1) clocks.
   localparam logic [3:0] SETUP_LOAD  = 4'(LD_SETUP_CYC - 1);
   localparam logic [3:0] STROBE_LOAD = 4'(LD_STROBE_CYC - 1);
   localparam logic [3:0] HOLD_LOAD   = 4'(LD_HOLD_CYC - 1);

   state_t     state;
   logic [3:0] phase_cnt;
   logic       bus_sel_q;
   logic       ld_we_q;
   logic [1:0] hit_sync;
   logic       z80_hit;
   logic       z80_hit_s;
   logic       in_window;
   logic       ld_busy;

   // A valid Z80 window access needs MREQ, an in-window address and exactly
   // one of RD/WR; both-low or both-high is treated as no access.
   assign in_window = (Addr >= WIN_LO) && (Addr <= WIN_HI);
   assign z80_hit   = !MREQ_N && in_window && (RD_N ^ WR_N);
   assign z80_hit_s = hit_sync[1];
   assign ld_busy   = (state == S_LD_SETUP) || (state == S_LD_STROBE) ||
                      (state == S_LD_HOLD);
   assign dbg_state = state;

   // Two-flop synchronizer: the Z80 bus is asynchronous to CLK, and only the
   // arbitration decision uses the synchronized hit.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         hit_sync <= 2'b00;
      end else begin
         hit_sync <= {hit_sync[0], z80_hit};
      end
   end

   // Arbitration and loader phase sequencing.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state     <= S_IDLE;
         phase_cnt <= 4'd0;
         bus_sel_q <= 1'b0;
         ld_we_q   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (z80_hit_s) begin
                  state <= S_Z80;
               end else if (LD_REQ) begin
                  state     <= S_LD_SETUP;
                  phase_cnt <= SETUP_LOAD;
                  bus_sel_q <= 1'b1;
                  ld_we_q   <= LD_WE;
               end
            end
            S_Z80: begin
               // Loader requests wait until the Z80 releases the window.
               if (!z80_hit_s) begin
                  state <= S_IDLE;
               end
            end
            S_LD_SETUP: begin
               if (phase_cnt == 4'd0) begin
                  state     <= S_LD_STROBE;
                  phase_cnt <= STROBE_LOAD;
               end else begin
                  phase_cnt <= phase_cnt - 4'd1;
               end
            end
            S_LD_STROBE: begin
               if (phase_cnt == 4'd0) begin
                  state     <= S_LD_HOLD;
                  phase_cnt <= HOLD_LOAD;
               end else begin
                  phase_cnt <= phase_cnt - 4'd1;
               end
            end
            S_LD_HOLD: begin
               if (phase_cnt == 4'd0) begin
                  state     <= S_IDLE;
                  bus_sel_q <= 1'b0;
               end else begin
                  phase_cnt <= phase_cnt - 4'd1;
               end
            end
            default: begin
               state     <= S_IDLE;
               phase_cnt <= 4'd0;
               bus_sel_q <= 1'b0;
            end
         endcase
      end
   end

   // SRAM strobe, wait and acknowledge generation. Outside loader cycles the
   // Z80 strobes follow the live bus with no clock latency; inside a loader
   // cycle the loader owns the strobes and a Z80 hit only raises WAIT.
   // Reset forces everything inactive at once, even with the Z80 bus active.
   always_comb begin
      RAM_CS_N = 1'b1;
      RAM_OE_N = 1'b1;
      RAM_WE_N = 1'b1;
      WAIT_N   = 1'b1;
      LD_ACK   = 1'b0;
      BUS_SEL  = bus_sel_q;
      if (!RESET) begin
         if (ld_busy) begin
            RAM_CS_N = 1'b0;
            WAIT_N   = !z80_hit;
            if (state == S_LD_STROBE) begin
               RAM_WE_N = !ld_we_q;
               RAM_OE_N = ld_we_q;
            end
            if ((state == S_LD_HOLD) && (phase_cnt == 4'd0)) begin
               LD_ACK = 1'b1;
            end
         end else begin
            RAM_CS_N = !z80_hit;
            RAM_OE_N = !(z80_hit && !RD_N);
            RAM_WE_N = !(z80_hit && !WR_N);
         end
      end
   end

`ifdef SRAM_SHARE_LED_STRETCH_EN
   logic [LED_STRETCH_W-1:0] led1_cnt;
   logic [LED_STRETCH_W-1:0] led2_cnt;

   // Stretch short SRAM activity so it is visible on the LEDs.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         led1_cnt <= '0;
         led2_cnt <= '0;
      end else begin
         if (!RAM_CS_N) begin
            led1_cnt <= '1;
         end else if (led1_cnt != '0) begin
            led1_cnt <= led1_cnt - LED_STRETCH_W'(1);
         end
         if (!RAM_WE_N) begin
            led2_cnt <= '1;
         end else if (led2_cnt != '0) begin
            led2_cnt <= led2_cnt - LED_STRETCH_W'(1);
         end
      end
   end

   assign led1 = (led1_cnt != '0);
   assign led2 = (led2_cnt != '0);
`else
   assign led1 = !RAM_CS_N;
   assign led2 = !RAM_WE_N;
`endif

endmodule

// File: tb/tb_sram_share_ctl.sv
// Directed testbench for sram_share_ctl (default build, default parameters).
// Inputs change 1 ns after the rising edge; outputs are checked 2 ns later,
// well away from both clock edges.

module tb_sram_share_ctl;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_Z80       = 3'd1;
   localparam logic [2:0] S_LD_SETUP  = 3'd2;
   localparam logic [2:0] S_LD_STROBE = 3'd3;
   localparam logic [2:0] S_LD_HOLD   = 3'd4;

   logic       CLK = 1'b0;
   logic       RESET;
   logic [4:0] Addr;
   logic       MREQ_N;
   logic       RD_N;
   logic       WR_N;
   logic       WAIT_N;
   logic       LD_REQ;
   logic       LD_WE;
   logic       LD_ACK;
   logic       BUS_SEL;
   logic       RAM_CS_N;
   logic       RAM_OE_N;
   logic       RAM_WE_N;
   logic       led1;
   logic       led2;
   logic [2:0] dbg_state;

   int total = 0;
   int bad = 0;
   int ack_cnt = 0;
   int ack_base = 0;

   sram_share_ctl dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .Addr     (Addr),
      .MREQ_N   (MREQ_N),
      .RD_N     (RD_N),
      .WR_N     (WR_N),
      .WAIT_N   (WAIT_N),
      .LD_REQ   (LD_REQ),
      .LD_WE    (LD_WE),
      .LD_ACK   (LD_ACK),
      .BUS_SEL  (BUS_SEL),
      .RAM_CS_N (RAM_CS_N),
      .RAM_OE_N (RAM_OE_N),
      .RAM_WE_N (RAM_WE_N),
      .led1     (led1),
      .led2     (led2),
      .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 CLK = ~CLK;

   // Count acknowledge pulses, sampled mid-cycle.
   always @(negedge CLK) begin
      if (LD_ACK === 1'b1) ack_cnt <= ack_cnt + 1;
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic z80_idle();
      MREQ_N = 1'b1;
      RD_N   = 1'b1;
      WR_N   = 1'b1;
      Addr   = 5'h00;
   endtask

   task automatic chk_strobes(input string tag, input logic cs, input logic oe, input logic we);
      chk({tag, "_cs"}, RAM_CS_N, cs);
      chk({tag, "_oe"}, RAM_OE_N, oe);
      chk({tag, "_we"}, RAM_WE_N, we);
   endtask

   initial begin
      // ---- reset state ----
      RESET  = 1'b1;
      LD_REQ = 1'b0;
      LD_WE  = 1'b0;
      z80_idle();
      settle();
      chk_strobes("rst", 1'b1, 1'b1, 1'b1);
      chk("rst_wait", WAIT_N, 1'b1);
      chk("rst_ack", LD_ACK, 1'b0);
      chk("rst_sel", BUS_SEL, 1'b0);
      chk("rst_led1", led1, 1'b0);
      chk("rst_led2", led2, 1'b0);
      tick();
      tick();
      RESET = 1'b0;
      settle();
      chk("rst_state", dbg_state, S_IDLE);

      // ---- Z80 read at window bottom, then just below the window ----
      tick();
      Addr = 5'h17; MREQ_N = 1'b0; RD_N = 1'b0;
      settle();
      chk_strobes("z80rd17", 1'b0, 1'b0, 1'b1);
      chk("z80rd17_wait", WAIT_N, 1'b1);
      chk("z80rd17_led1", led1, 1'b1);
      chk("z80rd17_led2", led2, 1'b0);
      chk("z80rd17_sel", BUS_SEL, 1'b0);
      tick();
      tick();
      chk("sync_2clk_idle", dbg_state, S_IDLE);
      tick();
      chk("sync_3clk_z80", dbg_state, S_Z80);
      Addr = 5'h16;
      settle();
      chk_strobes("z80rd16", 1'b1, 1'b1, 1'b1);
      chk("z80rd16_led1", led1, 1'b0);
      Addr = 5'h17; WR_N = 1'b0;
      settle();
      chk_strobes("z80_both_low", 1'b1, 1'b1, 1'b1);
      RD_N = 1'b1; WR_N = 1'b1;
      settle();
      chk_strobes("z80_both_high", 1'b1, 1'b1, 1'b1);
      z80_idle();
      tick();
      tick();
      chk("z80_release_hold", dbg_state, S_Z80);
      tick();
      chk("z80_release_idle", dbg_state, S_IDLE);

      // ---- loader write, bus idle ----
      ack_base = ack_cnt;
      LD_REQ = 1'b1; LD_WE = 1'b1;
      settle();
      chk("ldw_pre_sel", BUS_SEL, 1'b0);
      chk("ldw_pre_cs", RAM_CS_N, 1'b1);
      tick();
      chk("ldw_c1_state", dbg_state, S_LD_SETUP);
      chk_strobes("ldw_c1", 1'b0, 1'b1, 1'b1);
      chk("ldw_c1_sel", BUS_SEL, 1'b1);
      chk("ldw_c1_ack", LD_ACK, 1'b0);
      tick();
      chk_strobes("ldw_c2", 1'b0, 1'b1, 1'b0);
      chk("ldw_c2_led2", led2, 1'b1);
      chk("ldw_c2_ack", LD_ACK, 1'b0);
      tick();
      chk_strobes("ldw_c3", 1'b0, 1'b1, 1'b0);
      tick();
      chk_strobes("ldw_c4", 1'b0, 1'b1, 1'b1);
      chk("ldw_c4_ack", LD_ACK, 1'b1);
      chk("ldw_c4_sel", BUS_SEL, 1'b1);
      LD_REQ = 1'b0;
      tick();
      chk("ldw_c5_sel", BUS_SEL, 1'b0);
      chk("ldw_c5_ack", LD_ACK, 1'b0);
      chk("ldw_c5_cs", RAM_CS_N, 1'b1);
      chk("ldw_c5_state", dbg_state, S_IDLE);
      chk("ldw_ack_count", ack_cnt - ack_base, 1);

      // ---- Z80 write to 1F during loader read setup ----
      ack_base = ack_cnt;
      LD_REQ = 1'b1; LD_WE = 1'b0;
      tick();
      chk("zw_setup_state", dbg_state, S_LD_SETUP);
      Addr = 5'h1F; MREQ_N = 1'b0; WR_N = 1'b0;
      settle();
      chk("zw_setup_wait", WAIT_N, 1'b0);
      chk_strobes("zw_setup", 1'b0, 1'b1, 1'b1);
      tick();
      chk("zw_strobe_wait", WAIT_N, 1'b0);
      chk_strobes("zw_strobe", 1'b0, 1'b0, 1'b1);
      tick();
      chk("zw_strobe2_wait", WAIT_N, 1'b0);
      tick();
      chk("zw_hold_state", dbg_state, S_LD_HOLD);
      chk("zw_hold_wait", WAIT_N, 1'b0);
      chk("zw_hold_ack", LD_ACK, 1'b1);
      chk_strobes("zw_hold", 1'b0, 1'b1, 1'b1);
      LD_REQ = 1'b0;
      tick();
      chk("zw_idle_state", dbg_state, S_IDLE);
      chk("zw_idle_wait", WAIT_N, 1'b1);
      chk_strobes("zw_idle", 1'b0, 1'b1, 1'b0);
      chk("zw_idle_sel", BUS_SEL, 1'b0);
      tick();
      chk("zw_z80_state", dbg_state, S_Z80);
      chk("zw_z80_we", RAM_WE_N, 1'b0);
      z80_idle();
      tick();
      tick();
      tick();
      chk("zw_back_idle", dbg_state, S_IDLE);
      chk("zw_ack_count", ack_cnt - ack_base, 1);

      // ---- LD_REQ and z80_hit_s rise together: Z80 first ----
      ack_base = ack_cnt;
      Addr = 5'h18; MREQ_N = 1'b0; RD_N = 1'b0;
      tick();
      tick();
      LD_REQ = 1'b1; LD_WE = 1'b1;
      tick();
      chk("tie_z80_state", dbg_state, S_Z80);
      chk("tie_z80_sel", BUS_SEL, 1'b0);
      chk("tie_z80_oe", RAM_OE_N, 1'b0);
      tick();
      chk("tie_z80_hold", dbg_state, S_Z80);
      chk("tie_z80_wait", WAIT_N, 1'b1);
      z80_idle();
      tick();
      tick();
      chk("tie_sync_lag", dbg_state, S_Z80);
      tick();
      chk("tie_idle_slot", dbg_state, S_IDLE);
      tick();
      chk("tie_ld_start", dbg_state, S_LD_SETUP);
      chk("tie_ld_sel", BUS_SEL, 1'b1);
      tick();
      tick();
      tick();
      chk("tie_ld_ack", LD_ACK, 1'b1);
      LD_REQ = 1'b0;
      tick();
      chk("tie_ack_count", ack_cnt - ack_base, 1);

      // ---- three back-to-back loader writes ----
      ack_base = ack_cnt;
      LD_REQ = 1'b1; LD_WE = 1'b1;
      for (int a = 0; a < 3; a++) begin
         tick();
         chk($sformatf("b2b%0d_setup", a), dbg_state, S_LD_SETUP);
         tick();
         tick();
         tick();
         chk($sformatf("b2b%0d_ack", a), LD_ACK, 1'b1);
         if (a == 2) LD_REQ = 1'b0;
         tick();
         chk($sformatf("b2b%0d_idle", a), dbg_state, S_IDLE);
         chk($sformatf("b2b%0d_ack_low", a), LD_ACK, 1'b0);
         chk($sformatf("b2b%0d_sel", a), BUS_SEL, 1'b0);
      end
      tick();
      chk("b2b_stays_idle", dbg_state, S_IDLE);
      chk("b2b_ack_count", ack_cnt - ack_base, 3);

      // ---- LD_REQ dropped before ACK ----
      ack_base = ack_cnt;
      LD_REQ = 1'b1; LD_WE = 1'b0;
      tick();
      LD_REQ = 1'b0;
      tick();
      chk("drop_strobe_oe", RAM_OE_N, 1'b0);
      tick();
      tick();
      chk("drop_ack", LD_ACK, 1'b1);
      tick();
      tick();
      chk("drop_idle", dbg_state, S_IDLE);
      chk("drop_ack_count", ack_cnt - ack_base, 1);

      // ---- reset in the middle of a loader write strobe ----
      ack_base = ack_cnt;
      LD_REQ = 1'b1; LD_WE = 1'b1;
      tick();
      tick();
      chk("mrst_pre_we", RAM_WE_N, 1'b0);
      RESET = 1'b1;
      #1;
      chk_strobes("mrst", 1'b1, 1'b1, 1'b1);
      chk("mrst_sel", BUS_SEL, 1'b0);
      chk("mrst_ack", LD_ACK, 1'b0);
      chk("mrst_state", dbg_state, S_IDLE);
      tick();
      RESET  = 1'b0;
      LD_REQ = 1'b0;
      tick();
      tick();
      chk("mrst_after_state", dbg_state, S_IDLE);
      chk("mrst_after_cs", RAM_CS_N, 1'b1);
      chk("mrst_no_ack", ack_cnt - ack_base, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Guard against a stuck run.
   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
